// File: rtl/axil_crossbar_master_arb.sv
// ---------------------------------------------------------------------------
// axil_crossbar_master_arb
//
// Arbiter for one AXI-lite crossbar master interface on one address channel
// (AW or AR). S_COUNT slave-side decoders request this master. One of them
// is granted at a time. The grant is held until the responses for the
// transactions issued under it have completed. Because of this, B/R
// responses can be routed back without ID tracking.
//
// Optional build macro: AXIL_ARB_FIXED_PRIO_EN
//   undefined : round-robin selection (first requester at/after pointer)
//   defined   : fixed priority, lowest requesting index always wins
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   s_req        per-requester request, held until s_ack
//   s_ack        one-hot address-accepted pulse (grant & m_avalid & m_aready)
//   grant        registered one-hot grant
//   grant_enc    binary index of grant, meaningful while grant_valid
//   grant_valid  a grant is currently held
//   m_avalid     registered master address valid
//   m_aready     master address ready
//   m_resp_done  one master response handshake completed
//   err_resp     registered pulse: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module axil_crossbar_master_arb #(
    parameter int S_COUNT      = 4,
    parameter int ACCEPT_LIMIT = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [S_COUNT-1:0]                            s_req,
    output logic [S_COUNT-1:0]                            s_ack,
    output logic [S_COUNT-1:0]                            grant,
    output logic [((S_COUNT > 1) ? $clog2(S_COUNT) : 1)-1:0] grant_enc,
    output logic                                          grant_valid,
    output logic                                          m_avalid,
    input  logic                                          m_aready,
    input  logic                                          m_resp_done,
    output logic                                          err_resp
);

    localparam int ENC_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CNT_W = $clog2(ACCEPT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t             state_reg;
    logic [S_COUNT-1:0] grant_reg;
    logic [ENC_W-1:0]   grant_enc_reg;
    logic               grant_valid_reg;
    logic               m_avalid_reg;
    logic               err_resp_reg;
    logic [CNT_W-1:0]   outstanding_reg;
    logic [CNT_W-1:0]   outstanding_next;
    logic [CNT_W-1:0]   issued_reg;

    logic               addr_hs;
    logic               resp_dec;
    logic [ENC_W-1:0]   win_idx;
    logic [S_COUNT-1:0] win_onehot;

    // Lowest set bit of a request vector.
    function automatic logic [ENC_W-1:0] lowest_idx(input logic [S_COUNT-1:0] v);
        logic [ENC_W-1:0] idx;
        idx = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = k[ENC_W-1:0];
            end
        end
        return idx;
    endfunction

`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign win_idx = lowest_idx(s_req);
`else
    logic [ENC_W-1:0]   ptr_reg;
    logic [S_COUNT-1:0] req_masked;

    // Requests at or above the pointer take precedence. If none are present,
    // the unmasked vector supplies the wrap-around winner.
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_mask
        assign req_masked[gi] = s_req[gi] && (gi >= int'(ptr_reg));
    end

    assign win_idx = (|req_masked) ? lowest_idx(req_masked) : lowest_idx(s_req);
`endif

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign addr_hs  = (state_reg == ADDR) && m_avalid_reg && m_aready;
    // A response with nothing outstanding is dropped so that the counter
    // saturates at zero. It is flagged on err_resp.
    assign resp_dec = m_resp_done && (outstanding_reg != '0);

    always_comb begin
        outstanding_next = outstanding_reg;
        if (addr_hs && !resp_dec) begin
            outstanding_next = outstanding_reg + CNT_W'(1);
        end else if (!addr_hs && resp_dec) begin
            outstanding_next = outstanding_reg - CNT_W'(1);
        end
    end

    assign s_ack       = addr_hs ? grant_reg : '0;
    assign grant       = grant_reg;
    assign grant_enc   = grant_enc_reg;
    assign grant_valid = grant_valid_reg;
    assign m_avalid    = m_avalid_reg;
    assign err_resp    = err_resp_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            grant_enc_reg   <= '0;
            grant_valid_reg <= 1'b0;
            m_avalid_reg    <= 1'b0;
            err_resp_reg    <= 1'b0;
            outstanding_reg <= '0;
            issued_reg      <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            ptr_reg         <= '0;
`endif
        end else begin
            err_resp_reg    <= m_resp_done && (outstanding_reg == '0);
            outstanding_reg <= outstanding_next;
            case (state_reg)
                IDLE: begin
                    if (|s_req) begin
                        grant_reg       <= win_onehot;
                        grant_enc_reg   <= win_idx;
                        grant_valid_reg <= 1'b1;
                        m_avalid_reg    <= 1'b1;
                        state_reg       <= ADDR;
`ifndef AXIL_ARB_FIXED_PRIO_EN
                        if (int'(win_idx) == S_COUNT - 1) begin
                            ptr_reg <= '0;
                        end else begin
                            ptr_reg <= win_idx + ENC_W'(1);
                        end
`endif
                    end
                end
                ADDR: begin
                    // Once valid is raised it is held until the handshake,
                    // even if the requester withdraws.
                    if (addr_hs) begin
                        m_avalid_reg <= 1'b0;
                        issued_reg   <= issued_reg + CNT_W'(1);
                        state_reg    <= RESP;
                    end
                end
                RESP: begin
                    if ((int'(issued_reg) < ACCEPT_LIMIT) && s_req[grant_enc_reg]) begin
                        m_avalid_reg <= 1'b1;
                        state_reg    <= ADDR;
                    end else if (outstanding_next == '0) begin
                        grant_reg       <= '0;
                        grant_valid_reg <= 1'b0;
                        issued_reg      <= '0;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_crossbar_master_arb.sv
// ---------------------------------------------------------------------------
// tb_axil_crossbar_master_arb
//
// Two arbiter instances: dut_a (S_COUNT=4, ACCEPT_LIMIT=1) and
// dut_b (S_COUNT=4, ACCEPT_LIMIT=2). Directed stimulus pushes the expected
// address handshakes (winner index and cycle) and the expected err_resp
// cycles into queues. A negedge monitor pops these entries and compares them
// against the DUT outputs. The stimulus process also makes direct timing
// checks at 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_axil_crossbar_master_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] s_req_a;
    logic [3:0] s_ack_a;
    logic [3:0] grant_a;
    logic [1:0] grant_enc_a;
    logic       grant_valid_a;
    logic       m_avalid_a;
    logic       m_aready_a;
    logic       m_resp_done_a;
    logic       err_resp_a;

    logic [3:0] s_req_b;
    logic [3:0] s_ack_b;
    logic [3:0] grant_b;
    logic [1:0] grant_enc_b;
    logic       grant_valid_b;
    logic       m_avalid_b;
    logic       m_aready_b;
    logic       m_resp_done_b;
    logic       err_resp_b;

    axil_crossbar_master_arb #(.S_COUNT(4), .ACCEPT_LIMIT(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .s_req       (s_req_a),
        .s_ack       (s_ack_a),
        .grant       (grant_a),
        .grant_enc   (grant_enc_a),
        .grant_valid (grant_valid_a),
        .m_avalid    (m_avalid_a),
        .m_aready    (m_aready_a),
        .m_resp_done (m_resp_done_a),
        .err_resp    (err_resp_a)
    );

    axil_crossbar_master_arb #(.S_COUNT(4), .ACCEPT_LIMIT(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .s_req       (s_req_b),
        .s_ack       (s_ack_b),
        .grant       (grant_b),
        .grant_enc   (grant_enc_b),
        .grant_valid (grant_valid_b),
        .m_avalid    (m_avalid_b),
        .m_aready    (m_aready_b),
        .m_resp_done (m_resp_done_b),
        .err_resp    (err_resp_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int cyc;
    } ack_t;

    ack_t exp_ack_a[$];
    ack_t exp_ack_b[$];
    int   exp_err_a[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ack_a(input int idx, input int c);
        ack_t e;
        e.idx = idx;
        e.cyc = c;
        exp_ack_a.push_back(e);
    endtask

    task automatic push_ack_b(input int idx, input int c);
        ack_t e;
        e.idx = idx;
        e.cyc = c;
        exp_ack_b.push_back(e);
    endtask

    task automatic reset_duts();
        rst           = 1'b1;
        s_req_a       = '0;
        s_req_b       = '0;
        m_resp_done_a = 1'b0;
        m_resp_done_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (m_avalid_a && m_aready_a) begin
                check("ack_a_expected", 64'(exp_ack_a.size() != 0), 64'd1);
                if (exp_ack_a.size() != 0) begin
                    ack_t e;
                    e = exp_ack_a.pop_front();
                    $display("ack_a: src %0d at cycle %0d (expected src %0d cycle %0d)",
                             grant_enc_a, cyc, e.idx, e.cyc);
                    check("ack_a_idx", 64'(grant_enc_a), 64'(e.idx));
                    check("ack_a_onehot", 64'(s_ack_a), 64'(1) << e.idx);
                    check("ack_a_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("s_ack_a_quiet", 64'(s_ack_a), 64'd0);
            end

            if (m_avalid_b && m_aready_b) begin
                check("ack_b_expected", 64'(exp_ack_b.size() != 0), 64'd1);
                if (exp_ack_b.size() != 0) begin
                    ack_t e;
                    e = exp_ack_b.pop_front();
                    $display("ack_b: src %0d at cycle %0d (expected src %0d cycle %0d)",
                             grant_enc_b, cyc, e.idx, e.cyc);
                    check("ack_b_idx", 64'(grant_enc_b), 64'(e.idx));
                    check("ack_b_onehot", 64'(s_ack_b), 64'(1) << e.idx);
                    check("ack_b_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("s_ack_b_quiet", 64'(s_ack_b), 64'd0);
            end

            if (err_resp_a) begin
                check("err_a_expected", 64'(exp_err_a.size() != 0), 64'd1);
                if (exp_err_a.size() != 0) begin
                    int c;
                    c = exp_err_a.pop_front();
                    $display("err_a: pulse at cycle %0d (expected cycle %0d)", cyc, c);
                    check("err_a_cycle", 64'(cyc), 64'(c));
                end
            end
            check("err_b_quiet", 64'(err_resp_b), 64'd0);
        end
    end

    initial begin
        int base;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        int seq2[5] = '{0, 0, 0, 0, 0};
`else
        int seq2[5] = '{0, 1, 2, 3, 0};
`endif
        s_req_a       = '0;
        s_req_b       = '0;
        m_aready_a    = 1'b0;
        m_aready_b    = 1'b0;
        m_resp_done_a = 1'b0;
        m_resp_done_b = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_grant", 64'(grant_a), 64'd0);
        check("rst_grant_enc", 64'(grant_enc_a), 64'd0);
        check("rst_grant_valid", 64'(grant_valid_a), 64'd0);
        check("rst_m_avalid", 64'(m_avalid_a), 64'd0);
        check("rst_err_resp", 64'(err_resp_a), 64'd0);
        rst = 1'b0;

        // Test 1: single request, response at cycle 4, release at cycle 5
        tick();
        s_req_a = 4'b0001; m_aready_a = 1'b1; base = cyc;
        push_ack_a(0, base + 1);
        tick();
        check("t1_grant", 64'(grant_a), 64'h1);
        check("t1_m_avalid", 64'(m_avalid_a), 64'd1);
        tick();
        s_req_a = '0;
        check("t1_avalid_drop", 64'(m_avalid_a), 64'd0);
        check("t1_grant_held", 64'(grant_valid_a), 64'd1);
        tick();
        tick();
        m_resp_done_a = 1'b1;
        check("t1_held_c4", 64'(grant_valid_a), 64'd1);
        tick();
        m_resp_done_a = 1'b0;
        check("t1_release_c5", 64'(grant_valid_a), 64'd0);
        check("t1_grant_zero", 64'(grant_a), 64'd0);

        // Test 2: all four request, immediate ack and response
        reset_duts();
        m_aready_a = 1'b1;
        tick();
        s_req_a = 4'b1111; base = cyc;
        for (int i = 0; i < 5; i++) begin
            push_ack_a(seq2[i], base + 3 * i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            m_resp_done_a = 1'b1;
            if (i == 4) s_req_a = '0;
            tick();
            m_resp_done_a = 1'b0;
        end

        // Test 3: m_aready low 5 cycles on source 2, request withdrawn
        tick();
        s_req_a = 4'b0100; m_aready_a = 1'b0; base = cyc;
        push_ack_a(2, base + 6);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) s_req_a = '0;
            check("t3_avalid_held", 64'(m_avalid_a), 64'd1);
            check("t3_grant_enc", 64'(grant_enc_a), 64'd2);
        end
        tick();
        m_aready_a = 1'b1;
        tick();
        m_resp_done_a = 1'b1;
        check("t3_avalid_drop", 64'(m_avalid_a), 64'd0);
        tick();
        m_resp_done_a = 1'b0;
        check("t3_release", 64'(grant_valid_a), 64'd0);

        // Test 5: response while idle -> one-cycle err_resp
        tick();
        m_resp_done_a = 1'b1; base = cyc;
        exp_err_a.push_back(base + 1);
        tick();
        m_resp_done_a = 1'b0;
        check("t5_err_high", 64'(err_resp_a), 64'd1);
        check("t5_grant_idle", 64'(grant_valid_a), 64'd0);
        tick();
        check("t5_err_low", 64'(err_resp_a), 64'd0);

        // Test 6: asynchronous reset while in RESP with one outstanding
        tick();
        s_req_a = 4'b0001; base = cyc;
        push_ack_a(0, base + 1);
        tick();
        tick();
        s_req_a = '0;
        check("t6_in_resp", 64'(grant_valid_a), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_grant", 64'(grant_a), 64'd0);
        check("t6_async_avalid", 64'(m_avalid_a), 64'd0);
        check("t6_async_gvalid", 64'(grant_valid_a), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        m_resp_done_a = 1'b1; base = cyc;
        exp_err_a.push_back(base + 1);
        tick();
        m_resp_done_a = 1'b0;
        check("t6_err_high", 64'(err_resp_a), 64'd1);
        tick();
        check("t6_err_low", 64'(err_resp_a), 64'd0);

        // Test 4: ACCEPT_LIMIT=2, source 1, responses 4 cycles after each ack
        tick();
        s_req_b = 4'b0010; m_aready_b = 1'b1; base = cyc;
        push_ack_b(1, base + 1);
        push_ack_b(1, base + 3);
        tick();
        tick();
        check("t4_gap_avalid", 64'(m_avalid_b), 64'd0);
        tick();
        tick();
        s_req_b = '0;
        check("t4_avalid_c4", 64'(m_avalid_b), 64'd0);
        tick();
        m_resp_done_b = 1'b1;
        check("t4_avalid_c5", 64'(m_avalid_b), 64'd0);
        tick();
        m_resp_done_b = 1'b0;
        check("t4_held_c6", 64'(grant_valid_b), 64'd1);
        tick();
        m_resp_done_b = 1'b1;
        check("t4_held_c7", 64'(grant_valid_b), 64'd1);
        check("t4_avalid_c7", 64'(m_avalid_b), 64'd0);
        tick();
        m_resp_done_b = 1'b0;
        check("t4_release_c8", 64'(grant_valid_b), 64'd0);
        check("t4_grant_zero", 64'(grant_b), 64'd0);

        tick();
        tick();
        check("left_ack_a", 64'(exp_ack_a.size()), 64'd0);
        check("left_ack_b", 64'(exp_ack_b.size()), 64'd0);
        check("left_err_a", 64'(exp_err_a.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axil_crossbar_master_arb.md
Name: axil_crossbar_master_arb

Overview:
Per-master-interface arbiter for the AXI-lite crossbar. It shares one master address channel (AW or AR) among S_COUNT slave-side decoders that have selected this master.
- Grants one requester at a time and drives the master avalid.
- Holds the grant until that transaction's response (B or R) completes, so responses route back without ID tracking.
- One instance per master interface per channel.

Parameters:
S_COUNT, 4, number of requesters (slave interfaces); 1..32
ACCEPT_LIMIT, 1, transactions issued per grant before forced release (1..16); grant also released early if requester drops s_req

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_req  in  S_COUNT  per-requester request (decoded avalid targeting this master); must stay high until s_ack
s_ack  out  S_COUNT  one-hot pulse: requester's address accepted by master (combinational: grant & m_avalid & m_aready)
grant  out  S_COUNT  one-hot current grant (registered)
grant_enc  out  $clog2(S_COUNT) (min 1)  binary index of grant; valid while grant_valid
grant_valid  out  1  a grant is held
m_avalid  out  1  master address valid (registered)
m_aready  in  1  master address ready
m_resp_done  in  1  pulse: one response handshake completed on master side (bvalid&bready or rvalid&rready)
err_resp  out  1  registered 1-cycle pulse: m_resp_done received with nothing outstanding

Behaviour:
- Reset values: grant=0, grant_enc=0, grant_valid=0, m_avalid=0, err_resp=0, state=IDLE, outstanding=0, issued=0, rr pointer=0.
- States: IDLE, ADDR, RESP.
- IDLE:
  - If any s_req, pick winner by round-robin: first set bit at or after pointer, wrapping.
  - Next cycle: grant/grant_enc/grant_valid=1, m_avalid=1, pointer=(winner+1) mod S_COUNT, state ADDR. Request-to-m_avalid latency is 1 cycle.
- ADDR:
  - m_avalid held until m_aready, regardless of s_req.
  - On handshake: s_ack[winner] pulses same cycle, outstanding+1, issued+1, m_avalid drops next cycle, state RESP.
- RESP:
  - m_resp_done decrements outstanding.
  - If issued<ACCEPT_LIMIT and s_req[winner] is still high: reassert m_avalid next cycle and return to ADDR. Response may still be outstanding; outstanding never exceeds ACCEPT_LIMIT.
  - Otherwise wait until outstanding reaches 0. Then grant_valid=0 and grant=0 next cycle, issued=0, state IDLE.
  - Release-to-next-grant gap is 1 cycle: IDLE evaluates, grant registers the cycle after.
- m_resp_done in the same cycle as an address handshake: both apply, net outstanding unchanged.
- m_resp_done with outstanding==0: ignored (counter saturates at 0), err_resp pulses.
- Single requester repeatedly requesting with ACCEPT_LIMIT=1: gets grant every 3rd cycle minimum (IDLE, ADDR, RESP).
- S_COUNT=1: pointer is constant 0; grant_enc width 1.
- Reset mid-operation: all state cleared immediately; in-flight responses after reset are reported as err_resp.

Optional Feature:
AXIL_ARB_FIXED_PRIO_EN
- Defined: round-robin pointer removed; lowest-index requesting source always wins in IDLE. Starvation of high indices is permitted.
- Undefined: round-robin as above.
- All ports, latencies and the ADDR/RESP rules are identical in both builds.

Test Plan:
1. Reset, s_req=4'b0001, m_aready=1 -> grant=0001 and m_avalid at cycle 1; s_ack[0] pulse at cycle 1; m_resp_done at cycle 4 -> grant_valid=0 at cycle 5.
2. s_req=4'b1111 held, each transaction acked and responded immediately, ACCEPT_LIMIT=1 -> grant_enc sequence 0,1,2,3,0. With AXIL_ARB_FIXED_PRIO_EN: 0,0,0,...
3. m_aready low 5 cycles with grant on source 2 and s_req[2] dropped -> m_avalid stays 1 for all 5 cycles; s_ack[2] pulses on cycle m_aready rises.
4. ACCEPT_LIMIT=2, source 1 requests continuously, responses delayed 4 cycles -> two s_ack[1] pulses before any m_resp_done, m_avalid low until grant released; release only after second m_resp_done.
5. m_resp_done pulse while IDLE -> err_resp=1 for exactly one cycle; grant unchanged.
6. rst asserted while in RESP with outstanding=1 -> grant=0, m_avalid=0 asynchronously; subsequent m_resp_done -> err_resp pulse.
